// File: rtl/pool_stream_collector.sv
// Collects the pooled output stream into a first-word-fall-through FIFO, frames it against a
// sampled length and presents it on a valid/ready master port. Optional: POOL_COLLECT_MAXTRACK_EN.
module pool_stream_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNT_W-1:0]            frame_len,
  input  logic                        valid_in,
  input  logic signed [DATA_W-1:0]    data_in,
  output logic                        m_valid,
  output logic signed [DATA_W-1:0]    m_data,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overflow,
`ifdef POOL_COLLECT_MAXTRACK_EN
  output logic signed [DATA_W-1:0]    frame_max,
`endif
  output logic [$clog2(DEPTH):0]      level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W:0]     r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [CNT_W-1:0]    r_in_cnt;
  logic [CNT_W-1:0]    r_frame_len;
  logic                r_overflow;

  logic                w_count;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last_in;
  logic [DATA_W:0]     w_head;

  // Every valid word seen in COLLECT is counted, even when the FIFO is full and it is dropped.
  assign w_count   = (r_state == S_COLLECT) & valid_in & ~start;
  assign w_full    = (r_level == FULL_LVL);
  assign w_push    = w_count & ~w_full;
  assign w_pop     = (r_level != '0) & m_ready;
  assign w_cnt_inc = r_in_cnt + 1'b1;
  assign w_last_in = (w_cnt_inc == r_frame_len);
  assign w_head    = r_mem[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = S_IDLE;
      S_COLLECT: if (w_count && w_last_in) w_state_nxt = S_DRAIN;
      S_DRAIN:   if ((r_level == '0) || ((r_level == LW'(1)) && w_pop)) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    // start behaves identically in every state, including aborting a frame in progress.
    if (start) w_state_nxt = (frame_len == '0) ? S_DONE : S_COLLECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_in_cnt    <= '0;
      r_frame_len <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_frame_len <= frame_len;
        r_in_cnt    <= '0;
        r_overflow  <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_level     <= '0;
      end else begin
        if (w_count) begin
          r_in_cnt <= w_cnt_inc;
          if (w_full) r_overflow <= 1'b1;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // Storage holds data only; emptiness is tracked by r_level, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_last_in, data_in};
  end

  assign m_valid    = (r_level != '0);
  assign m_data     = m_valid ? $signed(w_head[DATA_W-1:0]) : '0;
  assign m_last     = m_valid ? w_head[DATA_W] : 1'b0;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign level      = r_level;

`ifdef POOL_COLLECT_MAXTRACK_EN
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] sat_max(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic signed [DATA_W-1:0] r_frame_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_max <= MOST_NEG;
    end else if (start) begin
      r_frame_max <= MOST_NEG;
    end else if (w_count) begin
      r_frame_max <= sat_max(r_frame_max, data_in);
    end
  end

  assign frame_max = r_frame_max;
`endif

endmodule

// File: tb/tb_pool_stream_collector.sv
// Scoreboard bench for pool_stream_collector: expected words are queued as they are driven and
// compared as they pop. Inputs change and outputs are sampled on the falling clock edge.
module tb_pool_stream_collector;

  logic               clk;
  logic               rst;
  logic               start;
  logic [15:0]        frame_len;
  logic               valid_in;
  logic signed [7:0]  data_in;
  logic               m_valid;
  logic signed [7:0]  m_data;
  logic               m_last;
  logic               m_ready;
  logic               busy;
  logic               frame_done;
  logic               overflow;
  logic [4:0]         level;
`ifdef POOL_COLLECT_MAXTRACK_EN
  logic signed [7:0]  frame_max;
`endif

  logic [8:0] q[$];
  int errors = 0;
  int checks = 0;

  pool_stream_collector #(.DATA_W(8), .DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .valid_in(valid_in), .data_in(data_in),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow),
`ifdef POOL_COLLECT_MAXTRACK_EN
    .frame_max(frame_max),
`endif
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; frame_len = '0; valid_in = 1'b0; data_in = '0; m_ready = 1'b0;
    #2;
    checks++;
    if ({m_valid, m_last, busy, frame_done, overflow, m_data, level} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {m_valid, m_last, busy, frame_done, overflow, m_data, level});
    end
`ifdef POOL_COLLECT_MAXTRACK_EN
    checks++;
    if (frame_max !== -8'sd128) begin errors++; $display("FAIL reset_frame_max got=%0d want=-128", frame_max); end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    logic signed [7:0] vals [4];
    logic [8:0] exp;
    logic done_ok;
    vals = '{8'sd5, -8'sd3, 8'sd7, 8'sd0};
    @(negedge clk); frame_len = 16'd4; start = 1'b1; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL basic_start busy=%b m_valid=%b want busy=1 m_valid=0", busy, m_valid);
    end
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = vals[i];
      q.push_back({(i == 3), vals[i]});
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== vals[i]) begin
        errors++; $display("FAIL basic_latency i=%0d m_valid=%b m_data=%0d want 1 %0d", i, m_valid, m_data, vals[i]);
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL basic_pop unexpected word %0d", m_data); end
        else begin
          exp = q.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL basic_pop got last=%b data=%0d want last=%b data=%0d", m_last, m_data, exp[8], $signed(exp[7:0]));
          end
        end
      end
    end
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    done_ok = frame_done;
    if (!done_ok || m_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL basic_done frame_done=%b m_valid=%b overflow=%b want 1 0 0", frame_done, m_valid, overflow);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || q.size() != 0) begin
      errors++; $display("FAIL basic_idle frame_done=%b busy=%b qsize=%0d want 0 0 0", frame_done, busy, q.size());
    end
  endtask

  task automatic test_overflow;
    logic [8:0] exp;
    int pops, last_pop, done_c;
    @(negedge clk); frame_len = 16'd20; start = 1'b1; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1; data_in = 8'(i);
      if (i < 16) q.push_back({1'b0, 8'(i)});
      @(negedge clk);
    end
    valid_in = 1'b0;
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL ovf_full level=%0d overflow=%b busy=%b frame_done=%b want 16 1 1 0", level, overflow, busy, frame_done);
    end
    @(negedge clk);
    checks++;
    if (m_data !== 8'sd0 || level !== 5'd16) begin
      errors++; $display("FAIL ovf_hold m_data=%0d level=%0d want 0 16", m_data, level);
    end
    m_ready = 1'b1; pops = 0; last_pop = -1; done_c = -1;
    for (int c = 0; c < 60; c++) begin
      if (frame_done) begin done_c = c; break; end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL ovf_pop unexpected word %0d", m_data); end
        else begin
          exp = q.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL ovf_pop got last=%b data=%0d want last=%b data=%0d", m_last, m_data, exp[8], $signed(exp[7:0]));
          end
        end
        pops++; last_pop = c;
      end
      @(negedge clk);
    end
    checks++;
    if (pops != 16 || done_c != last_pop + 1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drain pops=%0d done_cycle=%0d last_pop=%0d overflow=%b want 16 last_pop+1 1", pops, done_c, last_pop, overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_full_pop;
    logic [8:0] exp;
    logic done_ok;
    @(negedge clk); frame_len = 16'd20; start = 1'b1; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1; data_in = 8'(i); q.push_back({1'b0, 8'(i)});
      @(negedge clk);
    end
    checks++;
    if (level !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL fullpop_pre level=%0d overflow=%b want 16 0", level, overflow);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL fullpop_pop unexpected word %0d", m_data); end
        else begin
          exp = q.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL fullpop_pop got last=%b data=%0d want last=%b data=%0d", m_last, m_data, exp[8], $signed(exp[7:0]));
          end
        end
      end
      valid_in = 1'b1;
      if (i == 0) data_in = 8'sd99;
      else begin data_in = 8'(99 + i); q.push_back({(i == 3), 8'(99 + i)}); end
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (level !== 5'd15 || overflow !== 1'b1) begin
          errors++; $display("FAIL fullpop_drop level=%0d overflow=%b want 15 1", level, overflow);
        end
      end
    end
    valid_in = 1'b0; done_ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (frame_done) begin done_ok = 1'b1; break; end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL fullpop_pop unexpected word %0d", m_data); end
        else begin
          exp = q.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL fullpop_pop got last=%b data=%0d want last=%b data=%0d", m_last, m_data, exp[8], $signed(exp[7:0]));
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!done_ok || q.size() != 0) begin
      errors++; $display("FAIL fullpop_done frame_done_seen=%b qsize=%0d want 1 0", done_ok, q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len;
    @(negedge clk); frame_len = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL zero_done frame_done=%b busy=%b m_valid=%b want 1 1 0", frame_done, busy, m_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL zero_idle frame_done=%b busy=%b m_valid=%b want 0 0 0", frame_done, busy, m_valid);
    end
  endtask

  task automatic test_abort;
    logic [8:0] exp;
    logic done_ok;
    @(negedge clk); frame_len = 16'd40; start = 1'b1; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      valid_in = 1'b1; data_in = 8'(30 + i);
      if (i < 16) q.push_back({1'b0, 8'(30 + i)});
      @(negedge clk);
    end
    valid_in = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      checks++;
      exp = q.pop_front();
      if (m_valid !== 1'b1 || {m_last, m_data} !== exp) begin
        errors++; $display("FAIL abort_pop got v=%b last=%b data=%0d want last=%b data=%0d", m_valid, m_last, m_data, exp[8], $signed(exp[7:0]));
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    checks++;
    if (level !== 5'd3 || overflow !== 1'b1) begin
      errors++; $display("FAIL abort_pre level=%0d overflow=%b want 3 1", level, overflow);
    end
    start = 1'b1; frame_len = 16'd2; valid_in = 1'b1; data_in = 8'sd55;
    @(negedge clk); start = 1'b0; valid_in = 1'b0; q.delete();
    checks++;
    if (level !== 5'd0 || overflow !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_flush level=%0d overflow=%b m_valid=%b busy=%b want 0 0 0 1", level, overflow, m_valid, busy);
    end
    m_ready = 1'b1;
    valid_in = 1'b1; data_in = 8'sd21; q.push_back({1'b0, 8'sd21});
    @(negedge clk);
    valid_in = 1'b1; data_in = 8'sd22; q.push_back({1'b1, 8'sd22});
    done_ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) valid_in = 1'b0;
      if (frame_done) begin done_ok = 1'b1; break; end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL abort_pop unexpected word %0d", m_data); end
        else begin
          exp = q.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL abort_pop got last=%b data=%0d want last=%b data=%0d", m_last, m_data, exp[8], $signed(exp[7:0]));
          end
        end
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    checks++;
    if (!done_ok || q.size() != 0) begin
      errors++; $display("FAIL abort_done frame_done_seen=%b qsize=%0d want 1 0", done_ok, q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_drain;
    logic [8:0] exp;
    logic done_ok;
    logic signed [7:0] mv [3];
    mv = '{-8'sd128, 8'sd12, -8'sd5};
    @(negedge clk); frame_len = 16'd3; start = 1'b1; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = 8'(i + 1);
      @(negedge clk);
    end
    valid_in = 1'b0;
    checks++;
    if (level !== 5'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL rstdrain_pre level=%0d busy=%b want 3 1", level, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_last, busy, frame_done, overflow, m_data, level} !== 18'd0) begin
      errors++; $display("FAIL rstdrain_async got=%h want=0", {m_valid, m_last, busy, frame_done, overflow, m_data, level});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL rstdrain_after busy=%b level=%0d want 0 0", busy, level);
    end
    frame_len = 16'd3; start = 1'b1; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_valid && m_ready) begin
        checks++;
        exp = q.pop_front();
        if ({m_last, m_data} !== exp) begin
          errors++; $display("FAIL max_pop got last=%b data=%0d want last=%b data=%0d", m_last, m_data, exp[8], $signed(exp[7:0]));
        end
      end
      valid_in = 1'b1; data_in = mv[i]; q.push_back({(i == 2), mv[i]});
      @(negedge clk);
    end
    valid_in = 1'b0; done_ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (frame_done) begin done_ok = 1'b1; break; end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL max_pop unexpected word %0d", m_data); end
        else begin
          exp = q.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++; $display("FAIL max_pop got last=%b data=%0d want last=%b data=%0d", m_last, m_data, exp[8], $signed(exp[7:0]));
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!done_ok || q.size() != 0) begin
      errors++; $display("FAIL max_done frame_done_seen=%b qsize=%0d want 1 0", done_ok, q.size());
    end
`ifdef POOL_COLLECT_MAXTRACK_EN
    checks++;
    if (frame_max !== 8'sd12) begin errors++; $display("FAIL frame_max got=%0d want=12", frame_max); end
    @(negedge clk);
    checks++;
    if (frame_max !== 8'sd12) begin errors++; $display("FAIL frame_max_hold got=%0d want=12", frame_max); end
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_zero_len();
    test_abort();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
